dino_motion_ctrl: RTL and testbench

Per-frame state controller for the player dino sprite. Sequences run/jump/duck/dead behaviour and computes the jump trajectory (vertical position under gravity). Selects which dino sprite ROM image the VGA sprite datapath draws, including the two-phase running-leg animation. Sits between game-control inputs and the sprite datapath, and updates only at vertical blank so the drawn image never tears.

---
 rtl/dino_motion_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_ctrl.sv
// Player dino per-frame controller: run/jump/duck/dead sequencing, jump trajectory
// and sprite image selection, all updated only at vertical blank.
module dino_motion_ctrl #(
  parameter int unsigned GROUND_Y    = 200,
  parameter int unsigned JUMP_V0     = 12,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned ANIM_PERIOD = 6,
  parameter int unsigned Y_W         = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           jump_btn,
  input  logic           duck_btn,
  input  logic           collide,
  input  logic           restart,
  output logic [Y_W-1:0] dino_y,
  output logic [2:0]     sprite_sel,
  output logic [2:0]     state,
  output logic           dead
);

  localparam int unsigned SW = Y_W + 1;
  localparam int unsigned AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_JUMP = 3'd2,
    ST_DUCK = 3'd3,
    ST_DEAD = 3'd4
  } state_t;

  state_t            cur_st, nxt_st;
  logic signed [7:0] vel, vel_d;
  logic [AW-1:0]     anim_cnt, anim_d;
  logic              phase, phase_d;
  logic              col_pend, col_pend_d;
  logic              rst_pend, rst_pend_d;
  logic [Y_W-1:0]    y_d;
  logic [2:0]        sprite_d;
  logic              dead_d;
  logic              collide_ev, restart_ev;
  logic signed [SW-1:0] y_ext, vel_ext, y_calc;

  // Pulses arriving mid-frame are remembered until the next tick consumes them
  assign collide_ev = collide | col_pend;
  assign restart_ev = restart | rst_pend;

  assign y_ext   = $signed({1'b0, dino_y});
  assign vel_ext = {{(SW-8){vel[7]}}, vel};
  assign y_calc  = y_ext - vel_ext;
  assign state   = cur_st;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st     <= ST_IDLE;
      dino_y     <= Y_W'(GROUND_Y);
      vel        <= '0;
      anim_cnt   <= '0;
      phase      <= 1'b0;
      col_pend   <= 1'b0;
      rst_pend   <= 1'b0;
      sprite_sel <= 3'd0;
      dead       <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      dino_y     <= y_d;
      vel        <= vel_d;
      anim_cnt   <= anim_d;
      phase      <= phase_d;
      col_pend   <= col_pend_d;
      rst_pend   <= rst_pend_d;
      sprite_sel <= sprite_d;
      dead       <= dead_d;
    end
  end

  always_comb begin
    nxt_st     = cur_st;
    y_d        = dino_y;
    vel_d      = vel;
    anim_d     = anim_cnt;
    phase_d    = phase;
    col_pend_d = col_pend | collide;
    rst_pend_d = rst_pend | restart;
    sprite_d   = 3'd0;
    dead_d     = 1'b0;

    if (frame_tick) begin
      col_pend_d = 1'b0;
      rst_pend_d = 1'b0;
      if (restart_ev) begin
        nxt_st  = ST_IDLE;
        y_d     = Y_W'(GROUND_Y);
        vel_d   = '0;
        anim_d  = '0;
        phase_d = 1'b0;
      end else begin
        case (cur_st)
          ST_IDLE: begin
            if (jump_btn) begin
              nxt_st  = ST_RUN;
              anim_d  = '0;
              phase_d = 1'b0;
            end
          end
          ST_RUN: begin
            if (collide_ev) begin
              nxt_st = ST_DEAD;
            end else if (jump_btn) begin
              nxt_st = ST_JUMP;
              vel_d  = 8'(JUMP_V0);
            end else if (duck_btn) begin
              nxt_st = ST_DUCK;
            end else if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
              anim_d  = '0;
              phase_d = ~phase;
            end else begin
              anim_d = anim_cnt + AW'(1);
            end
          end
          ST_JUMP: begin
            // Position moves by the current velocity, then gravity slows it
            if (collide_ev) begin
              nxt_st = ST_DEAD;
            end else if (y_calc[SW-1]) begin
              y_d   = '0;
              vel_d = vel - 8'(GRAVITY);
            end else if (y_calc >= $signed(SW'(GROUND_Y))) begin
              y_d    = Y_W'(GROUND_Y);
              vel_d  = '0;
              nxt_st = duck_btn ? ST_DUCK : ST_RUN;
            end else begin
              y_d   = y_calc[Y_W-1:0];
              vel_d = vel - 8'(GRAVITY);
            end
          end
          ST_DUCK: begin
            if (collide_ev) begin
              nxt_st = ST_DEAD;
            end else if (jump_btn) begin
              nxt_st = ST_JUMP;
              vel_d  = 8'(JUMP_V0);
            end else if (!duck_btn) begin
              nxt_st = ST_RUN;
            end
          end
          ST_DEAD: begin
            nxt_st = ST_DEAD;
          end
          default: nxt_st = ST_IDLE;
        endcase
      end
    end

    case (nxt_st)
      ST_RUN:  sprite_d = phase_d ? 3'd2 : 3'd1;
      ST_JUMP: sprite_d = 3'd3;
      ST_DUCK: sprite_d = 3'd4;
      default: sprite_d = 3'd0;
    endcase
    dead_d = (nxt_st == ST_DEAD);
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl with hand-derived expectations.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       jump_btn = 1'b0;
  logic       duck_btn = 1'b0;
  logic       collide = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] dino_y;
  logic [2:0] sprite_sel;
  logic [2:0] state;
  logic       dead;

  int nvec = 0;
  int nerr = 0;

  dino_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .jump_btn   (jump_btn),
    .duck_btn   (duck_btn),
    .collide    (collide),
    .restart    (restart),
    .dino_y     (dino_y),
    .sprite_sel (sprite_sel),
    .state      (state),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame tick with optional same-cycle collide/restart pulses
  task automatic tick(input logic c = 1'b0, input logic r = 1'b0);
    frame_tick = 1'b1;
    collide    = c;
    restart    = r;
    @(negedge clk);
    frame_tick = 1'b0;
    collide    = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic pulse_collide();
    collide = 1'b1;
    @(negedge clk);
    collide = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    int ey;
    int ev;
    int exp_spr;

    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst_state", 32'(state), 0);
    chk("rst_y", 32'(dino_y), 200);
    chk("rst_spr", 32'(sprite_sel), 0);
    chk("rst_dead", 32'(dead), 0);

    // Idle frames, including a collide that must be ignored
    tick(); tick();
    pulse_collide();
    cyc(4);
    tick();
    chk("idle_state", 32'(state), 0);
    chk("idle_y", 32'(dino_y), 200);
    chk("idle_spr", 32'(sprite_sel), 0);
    chk("idle_dead", 32'(dead), 0);

    // Start running, then leg animation ticks 2..13
    jump_btn = 1'b1;
    tick();
    jump_btn = 1'b0;
    chk("run_state", 32'(state), 1);
    chk("run_spr_t1", 32'(sprite_sel), 1);
    for (int k = 2; k <= 13; k++) begin
      tick();
      exp_spr = (k <= 6) ? 1 : ((k <= 12) ? 2 : 1);
      chk($sformatf("run_spr_t%0d", k), 32'(sprite_sel), 32'(exp_spr));
    end
    cyc(3);
    chk("run_hold_spr", 32'(sprite_sel), 1);
    chk("run_hold_state", 32'(state), 1);

    // Anim counter to 3, duck 4 ticks, counter must hold
    tick(); tick(); tick();
    duck_btn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("duck_state_t%0d", k), 32'(state), 3);
      chk($sformatf("duck_spr_t%0d", k), 32'(sprite_sel), 4);
    end
    duck_btn = 1'b0;
    tick();
    chk("unduck_state", 32'(state), 1);
    chk("unduck_spr", 32'(sprite_sel), 1);
    tick(); tick();
    chk("unduck_spr_a5", 32'(sprite_sel), 1);
    tick();
    chk("unduck_spr_wrap", 32'(sprite_sel), 2);

    // Full jump from RUN; buttons during flight must not matter
    jump_btn = 1'b1;
    tick();
    jump_btn = 1'b0;
    chk("jmp_start_state", 32'(state), 2);
    chk("jmp_start_y", 32'(dino_y), 200);
    chk("jmp_start_spr", 32'(sprite_sel), 3);
    ey = 200;
    ev = 12;
    for (int k = 1; k <= 25; k++) begin
      jump_btn = (k >= 3 && k <= 5);
      duck_btn = (k >= 6 && k <= 8);
      tick();
      ey = ey - ev;
      ev = ev - 1;
      if (ey >= 200) begin
        ey = 200;
        chk($sformatf("jmp_land_state_t%0d", k), 32'(state), 1);
        chk($sformatf("jmp_land_spr_t%0d", k), 32'(sprite_sel), 2);
      end else begin
        chk($sformatf("jmp_state_t%0d", k), 32'(state), 2);
        chk($sformatf("jmp_spr_t%0d", k), 32'(sprite_sel), 3);
      end
      chk($sformatf("jmp_y_t%0d", k), 32'(dino_y), 32'(ey));
    end
    jump_btn = 1'b0;
    duck_btn = 1'b0;
    chk("jmp_y_t1_hand", 32'(188), 32'(200 - 12));
    chk("jmp_landed_y", 32'(dino_y), 200);

    // Collide mid-air: pending flag waits 100 cycles for tick 5
    jump_btn = 1'b1;
    tick();
    jump_btn = 1'b0;
    tick(); tick(); tick(); tick();
    chk("col_t4_y", 32'(dino_y), 158);
    pulse_collide();
    cyc(100);
    chk("col_pending_state", 32'(state), 2);
    tick();
    chk("col_state", 32'(state), 4);
    chk("col_y", 32'(dino_y), 158);
    chk("col_dead", 32'(dead), 1);
    chk("col_spr", 32'(sprite_sel), 0);
    jump_btn = 1'b1;
    tick(); tick();
    jump_btn = 1'b0;
    chk("dead_hold_state", 32'(state), 4);
    chk("dead_hold_y", 32'(dino_y), 158);

    // Pending restart leaves DEAD
    pulse_restart();
    cyc(5);
    chk("rs_pending_state", 32'(state), 4);
    tick();
    chk("rs_state", 32'(state), 0);
    chk("rs_y", 32'(dino_y), 200);
    chk("rs_dead", 32'(dead), 0);

    // collide and restart coincident with a tick while running
    jump_btn = 1'b1;
    tick();
    jump_btn = 1'b0;
    chk("pri_run", 32'(state), 1);
    tick(1'b1, 1'b1);
    chk("pri_state", 32'(state), 0);
    chk("pri_y", 32'(dino_y), 200);
    chk("pri_dead", 32'(dead), 0);
    chk("pri_spr", 32'(sprite_sel), 0);

    // Synchronous reset mid-jump without a tick
    jump_btn = 1'b1;
    tick();
    tick();
    jump_btn = 1'b0;
    tick(); tick();
    chk("mid_y_pre", 32'(dino_y), 177);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_y", 32'(dino_y), 200);
    chk("mid_rst_spr", 32'(sprite_sel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
